// File: rtl/mem_access_ctrl.sv
// Memory-side access sequencer: steps MAR load, MDR load/capture and the read/write
// strobes for one CPU-issued access, with a wait-state timeout that aborts stalled accesses.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             rw,
  input  logic             mem_ready,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDR_read,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic [2:0] {
    IDLE, LD_MAR, LD_MDR, RD_WAIT, WR_WAIT, DONE, ERR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t state, state_nxt;
  logic   rw_q;
  logic   waiting;

  assign waiting = (state == RD_WAIT) || (state == WR_WAIT);

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      rw_q     <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) rw_q <= rw;
      // Both wait states are only ever entered from LD_MAR/LD_MDR, so clear there.
      if (state == LD_MAR || state == LD_MDR)
        wait_cnt <= '0;
      else if (waiting && !mem_ready)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    MDR_read  = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nxt = LD_MAR;
      LD_MAR: begin
        MARin     = 1'b1;
        state_nxt = rw_q ? LD_MDR : RD_WAIT;
      end
      LD_MDR: begin
        MDRin     = 1'b1;
        state_nxt = WR_WAIT;
      end
      RD_WAIT: begin
        mem_rd   = 1'b1;
        MDR_read = 1'b1;
        // Mealy capture: MDR latches Mdatain on the same edge ready is seen.
        if (mem_ready) begin
          MDRin     = 1'b1;
          state_nxt = DONE;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt = ERR;
        end
      end
      WR_WAIT: begin
        mem_wr = 1'b1;
        if (mem_ready)                   state_nxt = DONE;
        else if (wait_cnt == CNT_LAST)   state_nxt = ERR;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: reset, read/write sequencing, wait states,
// timeout, mid-access reset, ignored start and stuck-high ready.
module tb_mem_access_ctrl;

  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             clr, start, rw, mem_ready;
  logic             MARin, MDRin, MDR_read, mem_rd, mem_wr, busy, done, err;
  logic [CNT_W-1:0] wait_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Packed view: {MARin, MDRin, MDR_read, mem_rd, mem_wr, busy, done, err}
  localparam logic [7:0] O_IDLE  = 8'h00;
  localparam logic [7:0] O_MAR   = 8'h84;
  localparam logic [7:0] O_MDR   = 8'h44;
  localparam logic [7:0] O_RD    = 8'h34;
  localparam logic [7:0] O_RDCAP = 8'h74;
  localparam logic [7:0] O_WR    = 8'h0C;
  localparam logic [7:0] O_DONE  = 8'h06;
  localparam logic [7:0] O_ERR   = 8'h05;

  logic [7:0] obs;
  assign obs = {MARin, MDRin, MDR_read, mem_rd, mem_wr, busy, done, err};

  mem_access_ctrl #(.TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .start(start), .rw(rw), .mem_ready(mem_ready),
    .MARin(MARin), .MDRin(MDRin), .MDR_read(MDR_read), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .busy(busy), .done(done), .err(err), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Mutual-exclusion watch, sampled mid-cycle when inputs are settled.
  always @(negedge clk) begin
    chk("mutex_rd_wr", 32'(mem_rd & mem_wr), 32'd0);
    chk("mutex_mar_mdr", 32'(MARin & MDRin), 32'd0);
  end

  logic [7:0] rd_exp [4] = '{O_MAR, O_RDCAP, O_DONE, O_IDLE};
  logic [7:0] wr_exp [5] = '{O_MAR, O_MDR, O_WR, O_DONE, O_IDLE};

  initial begin
    int lat;
    clr = 1'b1; start = 1'b1; rw = 1'b0; mem_ready = 1'b0;

    // Reset wins over start for two edges
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      chk("rst_outs", 32'(obs), 32'(O_IDLE));
      chk("rst_cnt", 32'(wait_cnt), 32'd0);
    end
    clr = 1'b0;
    cyc(); #1;
    chk("post_rst_mar", 32'(obs), 32'(O_MAR));
    start = 1'b0; rw = 1'b1;  // rw change after accept must be ignored
    cyc(); #1;
    chk("rd_wait_enter", 32'(obs), 32'(O_RD));
    chk("rd_wait_cnt0", 32'(wait_cnt), 32'd0);
    for (int i = 0; i < 5; i++) cyc();
    #1;
    chk("rd_wait_cnt5", 32'(wait_cnt), 32'd5);
    chk("rd_wait_still", 32'(obs), 32'(O_RD));
    clr = 1'b1;
    cyc(); #1;
    chk("mid_rst_outs", 32'(obs), 32'(O_IDLE));
    chk("mid_rst_cnt", 32'(wait_cnt), 32'd0);
    clr = 1'b0;
    cyc();

    // Zero-wait read: 4 edges from accept to IDLE
    mem_ready = 1'b1; start = 1'b1; rw = 1'b0;
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      start = 1'b0;
      #1;
      chk("zw_read_seq", 32'(obs), 32'(rd_exp[i]));
      if (lat == 0 && !busy) lat = i + 1;
    end
    chk("zw_read_lat", 32'(lat), 32'd4);

    // Write with 3 wait states; start/rw churn while busy is ignored
    mem_ready = 1'b0; start = 1'b1; rw = 1'b1;
    cyc(); #1;
    chk("wr_mar", 32'(obs), 32'(O_MAR));
    start = 1'b0; rw = 1'b0;
    cyc();
    start = 1'b1; #1;
    chk("wr_ld_mdr", 32'(obs), 32'(O_MDR));
    for (int i = 0; i < 4; i++) begin
      cyc();
      start = i[0]; rw = ~i[0];
      if (i == 3) mem_ready = 1'b1;
      #1;
      chk("wr_wait_outs", 32'(obs), 32'(O_WR));
      chk("wr_wait_cnt", 32'(wait_cnt), 32'(i));
    end
    start = 1'b1;
    cyc(); mem_ready = 1'b0; #1;
    chk("wr_done", 32'(obs), 32'(O_DONE));
    chk("wr_done_cnt", 32'(wait_cnt), 32'd3);
    cyc(); #1;
    chk("start_in_done_ignored", 32'(obs), 32'(O_IDLE));
    start = 1'b0;
    cyc();

    // Timeout: 16 read wait cycles then err
    start = 1'b1; rw = 1'b0;
    cyc(); start = 1'b0; #1;
    chk("to_mar", 32'(obs), 32'(O_MAR));
    for (int i = 0; i < 16; i++) begin
      cyc(); #1;
      chk("to_wait_outs", 32'(obs), 32'(O_RD));
      chk("to_wait_cnt", 32'(wait_cnt), 32'(i));
    end
    cyc(); #1;
    chk("to_err", 32'(obs), 32'(O_ERR));
    cyc(); #1;
    chk("to_idle", 32'(obs), 32'(O_IDLE));

    // Ready on the last allowed cycle: success wins over timeout
    start = 1'b1;
    cyc(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (i == 15) mem_ready = 1'b1;
      #1;
      chk("late_rdy_wait", 32'(obs), 32'((i == 15) ? O_RDCAP : O_RD));
    end
    cyc(); #1;
    chk("late_rdy_done", 32'(obs), 32'(O_DONE));
    cyc(); #1;
    chk("late_rdy_idle", 32'(obs), 32'(O_IDLE));

    // Stuck-high ready across a write: LD_MDR still visited, 5 edges to IDLE
    mem_ready = 1'b1; start = 1'b1; rw = 1'b1;
    cyc();
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      start = 1'b0;
      #1;
      chk("stuck_wr_seq", 32'(obs), 32'(wr_exp[i]));
      if (lat == 0 && !busy) lat = i + 1;
    end
    chk("stuck_wr_lat", 32'(lat), 32'd5);
    mem_ready = 1'b0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequencer for the memory-side datapath: MAR load, MDR load/capture, memory read/write strobes.
- Drives the MDR register's enable and its Mdatain/BusMuxOut mux select (`read`), and handshakes with memory via `mem_ready`.
- The CPU control unit issues one `start` per memory access and waits for `done` or `err`.
- Pure control block: it contains no 32-bit data path.

Parameters:
- TIMEOUT, 16: maximum number of wait-state cycles in RD_WAIT/WR_WAIT before the access is aborted. Legal range is 1..2^CNT_W-1.
- CNT_W, 5: width of the wait-state counter.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- clr  in  1  reset: synchronous, active-high.
- start  in  1  request an access; sampled only in IDLE.
- rw  in  1  access type, sampled with start: 0 = read, 1 = write.
- mem_ready  in  1  memory has completed the current access.
- MARin  out  1  MAR load enable.
- MDRin  out  1  MDR register enable.
- MDR_read  out  1  MDR mux select: 1 = Mdatain (memory), 0 = BusMuxOut.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse: access completed successfully.
- err  out  1  one-cycle pulse: access timed out.
- wait_cnt  out  CNT_W  current wait-state count (debug/visibility).

Behaviour:
- States: IDLE, LD_MAR, LD_MDR, RD_WAIT, WR_WAIT, DONE, ERR.
- Reset: clr=1 at posedge forces state=IDLE and wait_cnt=0 from any state, including mid-access. All outputs are 0 in IDLE, so every output reads 0 after reset.
- clr has priority over start and mem_ready in the same cycle.
- rw is captured into an internal register when start is accepted. Later changes to rw are ignored until the next IDLE.
- Transitions:
  - IDLE: start=1 -> LD_MAR (capture rw); otherwise stay in IDLE.
  - LD_MAR: MARin=1 for exactly one cycle. Next state is RD_WAIT if rw=0, LD_MDR if rw=1.
  - LD_MDR: MDRin=1 and MDR_read=0 (MDR loads from the bus) for one cycle -> WR_WAIT.
  - RD_WAIT: mem_rd=1 and MDR_read=1. MDRin = mem_ready; this is a Mealy output, so MDR captures Mdatain on the same edge that ready is seen.
    - mem_ready=1 -> DONE.
  - WR_WAIT: mem_wr=1, MDR_read=0, MDRin=0.
    - mem_ready=1 -> DONE.
  - DONE: done=1 -> IDLE.
  - ERR: err=1 -> IDLE.
- Wait counter:
  - Cleared to 0 on entry to RD_WAIT or WR_WAIT.
  - Increments each cycle spent in RD_WAIT/WR_WAIT with mem_ready=0.
  - If mem_ready=0 while wait_cnt==TIMEOUT-1 -> ERR; no MDRin is asserted.
  - If mem_ready=1 in that same cycle, success wins.
- Stuck-ready protection: mem_ready is ignored in every state other than RD_WAIT and WR_WAIT, so a stuck-high ready cannot skip states.
- start handling: start is ignored whenever busy=1, including in the DONE/ERR cycle; there is no queuing. Back-to-back accesses therefore have at least one IDLE cycle between them.
- Latency, with the accepting edge as edge 0 and ready high on first sight:
  - Read: LD_MAR after edge 0, RD_WAIT after edge 1 (MDR captures at edge 2), DONE after edge 2, IDLE after edge 3. Total: 4 cycles, start to IDLE.
  - Write: one extra cycle for LD_MDR, so 5 cycles.
  - Each cycle of mem_ready=0 adds one cycle.
- Mutual exclusion: mem_rd and mem_wr are never high together. MARin and MDRin are never high together.

Test Plan:
- Reset: hold clr=1 for 2 cycles with start=1 -> all outputs 0, busy=0, wait_cnt=0. Then clr=0 with start=1, rw=0 -> MARin=1 on the next cycle.
- Zero-wait read: start=1, rw=0, mem_ready tied 1 -> MARin, then (mem_rd=1, MDR_read=1, MDRin=1), then done=1, then busy=0. Check exactly 4 busy cycles.
- Write with 3 wait states: start=1, rw=1, mem_ready rises on the 4th WR_WAIT cycle -> MARin, MDRin with MDR_read=0, mem_wr high for 4 cycles, then done pulse. Check wait_cnt reaches 3 and MDRin is never asserted during WR_WAIT.
- Timeout: TIMEOUT=16, read with mem_ready held 0 -> mem_rd high for 16 cycles, then err=1 for one cycle, done never asserted, MDRin never asserted, back to IDLE. Repeat with ready rising on wait_cnt==15 -> done, not err.
- Mid-access reset and ignored start: assert clr in RD_WAIT at wait_cnt=5 -> next cycle IDLE, mem_rd=0. Pulse start and toggle rw during a busy write -> no effect, the write completes as a write.
- Stuck-high ready: mem_ready=1 throughout a write -> LD_MDR is still visited, and mem_rd/mem_wr and MARin/MDRin are never concurrent (checked by assertions).
